// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: decodes the PS/2 set-2 byte stream (E0 / F0 / E1 pause
// prefixes) into single key events, queues them in a show-ahead FIFO and
// tracks the Caps/Num/Scroll lock state for the keyboard model.
//
// Ports:
//   CLOCK_50          in   system clock, rising edge
//   resetn            in   asynchronous active-low reset
//   key_action        in   byte strobe, rising edge marks a new byte
//   scan_code[7:0]    in   byte value, stable while key_action is high
//   evt_valid         out  FIFO non-empty
//   evt_data[9:0]     out  {extended, released, code[7:0]} at FIFO head
//   evt_ready         in   pop request (pop when evt_valid & evt_ready)
//   overflow          out  sticky, an event was dropped on a full FIFO
//   ps2_lock_control  out  lock state {Caps, Num, Scroll}
//
// Build option: define PS2_LOCK_TRACK_EN to enable lock tracking; without it
// ps2_lock_control is tied to 000 and decoding is unchanged.
module ps2_scan_decoder #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_action,
    input  logic [7:0] scan_code,
    output logic       evt_valid,
    output logic [9:0] evt_data,
    input  logic       evt_ready,
    output logic       overflow,
    output logic [2:0] ps2_lock_control
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } evt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       ka_q;
    logic       accept;
    logic       emit;
    evt_t       ev;

    assign accept = key_action & ~ka_q;

    // Prefix decoder: only accept cycles advance the state
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        emit    = 1'b0;
        ev      = '0;
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    case (scan_code)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_PAUSE;
                            skip_d  = 3'd7;
                        end
                        // keyboard acknowledge / status bytes carry no key
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: begin
                            emit = 1'b1;
                            ev   = '{ext: 1'b0, rel: 1'b0, code: scan_code};
                        end
                    endcase
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        emit    = 1'b1;
                        ev      = '{ext: 1'b1, rel: 1'b0, code: scan_code};
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    emit    = 1'b1;
                    ev      = '{ext: 1'b0, rel: 1'b1, code: scan_code};
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    emit    = 1'b1;
                    ev      = '{ext: 1'b1, rel: 1'b1, code: scan_code};
                    state_d = S_IDLE;
                end
                S_PAUSE: begin
                    // swallow the 7 trailing pause bytes, then report one E1
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        emit    = 1'b1;
                        ev      = '{ext: 1'b0, rel: 1'b0, code: 8'hE1};
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            skip_q  <= 3'd0;
            ka_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            ka_q    <= key_action;
        end
    end

    // Event FIFO: push+pop together always succeeds, even when full
    evt_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             overflow_q;
    logic             full, pop, wr_en;

    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop   = evt_ready & (cnt_q != '0);
    assign wr_en = emit & (~full | pop);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (emit & full & ~pop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem_q[wr_ptr_q] <= ev;
    end

    assign evt_valid = (cnt_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 10'h000;
    assign overflow  = overflow_q;

`ifdef PS2_LOCK_TRACK_EN
    logic [2:0] lock_q, lock_d;
    logic [2:0] held_q, held_d;
    logic [2:0] lock_sel;

    // Toggle on the first make only; typematic repeats leave the bit alone
    always_comb begin
        lock_d   = lock_q;
        held_d   = held_q;
        lock_sel = 3'b000;
        if (emit && !ev.ext) begin
            case (ev.code)
                8'h58:   lock_sel = 3'b100;
                8'h77:   lock_sel = 3'b010;
                8'h7E:   lock_sel = 3'b001;
                default: lock_sel = 3'b000;
            endcase
            if (ev.rel) begin
                held_d = held_q & ~lock_sel;
            end else begin
                lock_d = lock_q ^ (lock_sel & ~held_q);
                held_d = held_q | lock_sel;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lock_q <= 3'b000;
            held_q <= 3'b000;
        end else begin
            lock_q <= lock_d;
            held_q <= held_d;
        end
    end

    assign ps2_lock_control = lock_q;
`else
    assign ps2_lock_control = 3'b000;
`endif

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Consumer end of the board keyboard path: accepts the byte stream the simulated PS/2 keyboard presents on `key_action`/`scan_code` and decodes set-2 prefixes (E0, F0, E1 pause) into single key events. Events are queued in a show-ahead FIFO for user logic. The block also tracks Caps/Num/Scroll lock state and drives `ps2_lock_control` back to the keyboard model. It sits inside the DUT between the top-level keyboard ports and application logic.

## Interface
- `FIFO_DEPTH`, 8: event queue depth; power of two, ≥2.
- `CLOCK_50`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `key_action`  in  1  byte strobe; a rising edge (sampled on `CLOCK_50`) marks a new byte.
- `scan_code`  in  8  byte value; stable whenever `key_action` is high.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_data`  out  10  {extended, released, code[7:0]} at FIFO head.
- `evt_ready`  in  1  pop request; a pop occurs when `evt_valid & evt_ready`.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `ps2_lock_control`  out  3  lock state: bit2 Caps, bit1 Num, bit0 Scroll.

## Operation
- Edge detect: register `key_action` into `ka_d`. The accept cycle T is any cycle with `key_action & ~ka_d`. Only accept cycles advance the FSM.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → PAUSE with skip counter = 7.
    - FA, AA, EE, FE, 00, FF are ignored and the FSM stays in IDLE.
    - Any other byte emits {0,0,byte}.
  - EXT: F0 → EXT_BRK; any other byte emits {1,0,byte} → IDLE.
  - BRK: emits {0,1,byte} → IDLE.
  - EXT_BRK: emits {1,1,byte} → IDLE.
  - PAUSE: decrement the counter on each byte. When the counter reaches 0, emit {0,0,E1} → IDLE. Bytes inside the pause sequence (including 77) never emit events and never affect lock state.
- FIFO:
  - Show-ahead: `evt_data` is valid whenever `evt_valid` is high.
  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide; read and write pointers wrap modulo FIFO_DEPTH.
  - Push when full without a simultaneous pop: event dropped, `overflow` set to 1. `overflow` is cleared only by reset.
  - Push and pop in the same cycle: both succeed at any occupancy, including full. Count is unchanged and `overflow` is not set.
  - Pop when empty: ignored.
- Lock tracking (non-extended codes only):
  - Lock keys: 58 = Caps, 77 = Num, 7E = Scroll. Each key has a `held` flag.
  - Make with `held`=0: toggle the lock bit and set `held`.
  - Make with `held`=1 (typematic repeat): no toggle.
  - Break: clear `held`.
  - Extended lock codes (e.g. E0 7E) affect neither `held` nor the lock bit.
  - The event is queued regardless of lock handling.

## Timing
- Reset values: `evt_valid`=0, `evt_data`=0, `overflow`=0, `ps2_lock_control`=000.
- Reset also forces: FSM to IDLE, FIFO empty, all `held` flags 0, `ka_d`=0.
- Reset asserted mid-sequence discards any pending prefix or pause count. The first byte after reset is decoded from IDLE.
- Latency: byte accepted at T → event written at the end of T → `evt_valid`=1 at T+1 if the FIFO was empty.
- Lock bit updates at the end of T and is visible at T+1.
- Pop at cycle P: the new head, or `evt_valid`=0, is visible at P+1.
- `key_action` held high for many cycles counts as one byte. Consecutive bytes need a low cycle between them; the minimum period is 2 cycles.

## Configuration
- `PS2_LOCK_TRACK_EN` defined: lock tracking as described above.
- `PS2_LOCK_TRACK_EN` undefined: `held` flags and lock logic are omitted. `ps2_lock_control` is constant 000. Event decoding is unchanged.

## Test plan
- Bytes 1C; F0 1C with `evt_ready`=1 → events 0x01C then 0x11C; `evt_valid` rises 1 cycle after each accept.
- E0 75; E0 F0 75 → events 0x275 then 0x375; no lock change.
- 58, 58, 58 (typematic), F0 58, then 58 → `ps2_lock_control`=100 after the first make, still 100 through the repeats and break, 000 after the final make; 5 events queued.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event, 0x0E1; Num bit stays 0.
- `evt_ready`=0, FIFO_DEPTH=8, 9 make codes → `evt_valid` stays 1, `overflow`=1, 8 events drain in order. A push coinciding with a pop at full leaves `overflow` at its prior value.
- Send E0, assert `resetn`=0 for 1 cycle, then send 7E → all outputs reset; event 0x07E; Scroll bit becomes 1.
